// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared constants, segment code table and digit index type for the scanned display.
package disp_pkg;

  typedef logic [1:0] digit_idx_t;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Active-low codes, bit 0 = segment a ... bit 6 = segment g.
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/hex7seg.sv
// rtl/hex7seg.sv - combinational hex value to active-low seven-segment code.
module hex7seg
  import disp_pkg::*;
(
  input  logic [3:0] val,
  output logic [6:0] code
);

  always_comb begin
    code = SEG_TABLE[val];
  end

endmodule

// File: rtl/disp_scan.sv
// rtl/disp_scan.sv - four-digit multiplexed seven-segment scanner with guard blanking per slot.
// Optional leading-zero blanking on digits 3..1 when DISP_BLANK_EN is defined.
module disp_scan
  import disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [4:0] seg0wr,
  input  logic [4:0] seg1wr,
  input  logic [4:0] seg2wr,
  input  logic [4:0] seg3wr,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);

  logic [CW-1:0] cnt;
  digit_idx_t    idx;
  logic [4:0]    cur;
  logic [6:0]    dec;
  logic [6:0]    seg_d;
  logic [3:0]    an_d;

  // The scan keeps running while disabled so re-enabling resumes mid-sequence.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    cur = seg0wr;
    case (idx)
      2'd0:    cur = seg0wr;
      2'd1:    cur = seg1wr;
      2'd2:    cur = seg2wr;
      default: cur = seg3wr;
    endcase
  end

  hex7seg u_hex7seg (
    .val  (cur[3:0]),
    .code (dec)
  );

`ifdef DISP_BLANK_EN
  logic z3, z2, z1;
  logic blank;

  assign z3 = (seg3wr[3:0] == 4'h0);
  assign z2 = z3 && (seg2wr[3:0] == 4'h0);
  assign z1 = z2 && (seg1wr[3:0] == 4'h0);

  always_comb begin
    blank = 1'b0;
    case (idx)
      2'd3:    blank = z3;
      2'd2:    blank = z2;
      2'd1:    blank = z1;
      default: blank = 1'b0;
    endcase
    seg_d = blank ? SEG_OFF : dec;
  end
`else
  always_comb begin
    seg_d = dec;
  end
`endif

  always_comb begin
    an_d = AN_OFF;
    if (en && (cnt >= GUARD_C)) begin
      an_d = ~(4'b0001 << idx);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= AN_OFF;
      seg <= SEG_OFF;
      dp  <= 1'b1;
    end else begin
      an  <= an_d;
      seg <= seg_d;
      dp  <= ~cur[4];
    end
  end

endmodule

// File: tb/tb_disp_scan.sv
// tb/tb_disp_scan.sv - directed self-checking bench for disp_scan with REFRESH_DIV=8, GUARD=2.
module tb_disp_scan;

  logic       clk;
  logic       rst;
  logic       en;
  logic [4:0] seg0wr, seg1wr, seg2wr, seg3wr;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int total = 0;
  int bad   = 0;

  disp_scan #(.REFRESH_DIV(8), .GUARD(2)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .seg0wr (seg0wr),
    .seg1wr (seg1wr),
    .seg2wr (seg2wr),
    .seg3wr (seg3wr),
    .an     (an),
    .seg    (seg),
    .dp     (dp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_an(input logic [3:0] want, input string tag);
    int n;
    n = 0;
    while (an !== want && n < 40) begin
      tick();
      n++;
    end
    check(tag, {7'd0, (an === want)}, 8'd1);
  endtask

  initial begin
    logic [3:0] one_hot;
    logic [3:0] e_an;
    logic [6:0] e_hi;
    int pos;
    int slot;

    rst = 1'b0;
    en = 1'b1;
    seg3wr = 5'h01;
    seg2wr = 5'h02;
    seg1wr = 5'h03;
    seg0wr = 5'h04;

    // Asynchronous reset before any clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst_an", {4'd0, an}, 8'h0F);
    check("rst_seg", {1'b0, seg}, 8'h7F);
    check("rst_dp", {7'd0, dp}, 8'h01);

    @(negedge clk);
    rst = 1'b0;

    // Full scan of four slots plus the start of the next.
    for (int t = 1; t <= 34; t++) begin
      tick();
      pos = (t - 1) % 8;
      slot = ((t - 1) / 8) % 4;
      one_hot = 4'b0001 << slot;
      e_an = (pos < 2) ? 4'hF : ~one_hot;
      check($sformatf("scan_an_t%0d", t), {4'd0, an}, {4'd0, e_an});
      if (t == 3) begin
        check("scan_seg_d0", {1'b0, seg}, 8'h19);
        check("scan_dp_d0", {7'd0, dp}, 8'h01);
      end
      if (t == 11) check("scan_seg_d1", {1'b0, seg}, 8'h30);
      if (t == 19) check("scan_seg_d2", {1'b0, seg}, 8'h24);
      if (t == 27) check("scan_seg_d3", {1'b0, seg}, 8'h79);
    end

    seg2wr = 5'h0F;
    wait_an(4'b1011, "wait_d2_F");
    check("hexF_seg", {1'b0, seg}, 8'h0E);
    check("hexF_dp", {7'd0, dp}, 8'h01);

    seg1wr = 5'h15;
    wait_an(4'b1101, "wait_d1_5dp");
    check("hex5_seg", {1'b0, seg}, 8'h12);
    check("hex5_dp", {7'd0, dp}, 8'h00);

    // Mid-slot input change lands on the very next cycle.
    seg1wr = 5'h08;
    tick();
    check("midslot_seg", {1'b0, seg}, 8'h00);
    check("midslot_dp", {7'd0, dp}, 8'h01);

    // Disable mid-slot (cnt=4 of digit 1), re-enable at cnt=7.
    en = 1'b0;
    tick();
    check("en_off_an", {4'd0, an}, 8'h0F);
    tick();
    tick();
    check("en_off_an2", {4'd0, an}, 8'h0F);
    en = 1'b1;
    tick();
    check("en_on_lit", {4'd0, an}, 8'h0D);

    // Re-enable inside the guard window stays dark until cnt reaches GUARD.
    en = 1'b0;
    tick();
    en = 1'b1;
    tick();
    check("en_on_guard", {4'd0, an}, 8'h0F);
    tick();
    check("en_on_guard_end", {4'd0, an}, 8'h0B);

    // A full disabled slot: counters keep running underneath.
    en = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    check("en_off_slot", {4'd0, an}, 8'h0F);
    en = 1'b1;
    tick();
    check("en_resume_d3", {4'd0, an}, 8'h07);

    // Reset at cnt=5, idx=2.
    wait_an(4'b1011, "wait_d2_rst");
    tick();
    tick();
    check("pre_rst_an", {4'd0, an}, 8'h0B);
    rst = 1'b1;
    #1;
    check("mid_rst_an", {4'd0, an}, 8'h0F);
    check("mid_rst_seg", {1'b0, seg}, 8'h7F);
    check("mid_rst_dp", {7'd0, dp}, 8'h01);
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post_rst_c1", {4'd0, an}, 8'h0F);
    tick();
    check("post_rst_c2", {4'd0, an}, 8'h0F);
    tick();
    check("post_rst_c3", {4'd0, an}, 8'h0E);
    check("post_rst_seg", {1'b0, seg}, 8'h19);

    // Leading-zero digits; dp request on digit 3 must survive blanking.
    seg3wr = 5'h10;
    seg2wr = 5'h00;
    seg1wr = 5'h07;
    seg0wr = 5'h00;
`ifdef DISP_BLANK_EN
    e_hi = 7'h7F;
`else
    e_hi = 7'h40;
`endif
    wait_an(4'b1101, "wait_lz_d1");
    check("lz_d1_seg", {1'b0, seg}, 8'h78);
    wait_an(4'b1011, "wait_lz_d2");
    check("lz_d2_seg", {1'b0, seg}, {1'b0, e_hi});
    wait_an(4'b0111, "wait_lz_d3");
    check("lz_d3_seg", {1'b0, seg}, {1'b0, e_hi});
    check("lz_d3_dp", {7'd0, dp}, 8'h00);
    wait_an(4'b1110, "wait_lz_d0");
    check("lz_d0_seg", {1'b0, seg}, 8'h40);
    check("lz_d0_dp", {7'd0, dp}, 8'h01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
